// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared types and default sizes for the BRAM port arbiter.
//   - arb_state_e : arbiter FSM state (IDLE / LOCK)
//   - arb_owner_e : which requester owns an in-flight read
//   - cnt_width() : bits needed to hold a saturating count 0..limit
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_CPU = 1'b0,
        ARB_OWN_LDR = 1'b1
    } arb_owner_e;

    localparam int ARB_ADDR_W     = 14;
    localparam int ARB_DATA_W     = 32;
    localparam int ARB_STARVE_LIM = 8;
    localparam int ARB_MAX_BURST  = 16;

    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_sat_counter
//   Saturating up-counter 0..LIMIT with synchronous clear.
//   A clear together with an increment loads 1, so the beat that starts a
//   sequence is counted in the same cycle that resets the count.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-low reset
//   clr_i  in   clear (or load 1 when inc_i is also set)
//   inc_i  in   increment, ignored once saturated
//   cnt_o  out  current count
//   sat_o  out  count == LIMIT
// -----------------------------------------------------------------------------
module mem_port_arbiter_sat_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign sat_o = (cnt_q == W'(LIMIT));
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = inc_i ? W'(1) : '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one BRAM port between the CPU memory stage and the serial program
//   loader. One grant per cycle (combinational, same cycle), CPU first unless
//   the loader has been denied STARVE_LIM cycles in a row. A loader grant with
//   ldr_lock enters LOCK, where the loader owns the port except for one forced
//   CPU slot after every MAX_BURST loader beats. Read data (1-cycle BRAM
//   latency) is routed back to whichever side issued the read.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cpu_req/we/addr/din      CPU access request
//   cpu_gnt                  CPU access accepted this cycle
//   cpu_rvalid/cpu_dout      CPU read return
//   ldr_req/lock/we/addr/din loader access request (lock = burst)
//   ldr_gnt                  loader access accepted this cycle
//   ldr_rvalid/ldr_dout      loader read return
//   mem_en/we/addr/din       BRAM request side
//   mem_dout                 BRAM read data, one cycle after mem_en
//   dbg_state                FSM state
//   dbg_starve_cnt           consecutive loader denials
//   dbg_burst_cnt            loader beats in the current locked burst
//
// Handshake: an access happens in the cycle where req and gnt are both high;
// a requester seeing req & ~gnt must hold its request (stall). rvalid is a
// single-cycle pulse one cycle after a granted read, with no back-pressure.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int STARVE_LIM = ARB_STARVE_LIM,
    parameter int MAX_BURST  = ARB_MAX_BURST
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cpu_req,
    input  logic [DATA_W/8-1:0]                    cpu_we,
    input  logic [ADDR_W-1:0]                      cpu_addr,
    input  logic [DATA_W-1:0]                      cpu_din,
    output logic                                   cpu_gnt,
    output logic                                   cpu_rvalid,
    output logic [DATA_W-1:0]                      cpu_dout,
    input  logic                                   ldr_req,
    input  logic                                   ldr_lock,
    input  logic [DATA_W/8-1:0]                    ldr_we,
    input  logic [ADDR_W-1:0]                      ldr_addr,
    input  logic [DATA_W-1:0]                      ldr_din,
    output logic                                   ldr_gnt,
    output logic                                   ldr_rvalid,
    output logic [DATA_W-1:0]                      ldr_dout,
    output logic                                   mem_en,
    output logic [DATA_W/8-1:0]                    mem_we,
    output logic [ADDR_W-1:0]                      mem_addr,
    output logic [DATA_W-1:0]                      mem_din,
    input  logic [DATA_W-1:0]                      mem_dout,
    output arb_state_e                             dbg_state,
    output logic [cnt_width(STARVE_LIM)-1:0]       dbg_starve_cnt,
    output logic [cnt_width(MAX_BURST)-1:0]        dbg_burst_cnt
);

    arb_state_e state_q, state_d;
    logic       rd_pend_q, rd_pend_d;
    arb_owner_e rd_owner_q, rd_owner_d;

    logic starve_sat;
    logic burst_sat;
    logic burst_clr;
    logic burst_inc;

    // Grant decision. Gated by rst so nothing is granted while in reset.
    always_comb begin
        cpu_gnt = 1'b0;
        ldr_gnt = 1'b0;
        if (rst) begin
            if (state_q == ARB_IDLE) begin
                if (cpu_req && (!ldr_req || !starve_sat)) begin
                    cpu_gnt = 1'b1;
                end else if (ldr_req) begin
                    ldr_gnt = 1'b1;
                end
            end else begin
                // LOCK: the CPU only gets the forced slot after a full burst.
                if (burst_sat && cpu_req) begin
                    cpu_gnt = 1'b1;
                end else if (ldr_req) begin
                    ldr_gnt = 1'b1;
                end
            end
        end
    end

    // BRAM request mux: idle port drives all zeros.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = '0;
        mem_addr = '0;
        mem_din  = '0;
        if (cpu_gnt) begin
            mem_en   = 1'b1;
            mem_we   = cpu_we;
            mem_addr = cpu_addr;
            mem_din  = cpu_din;
        end else if (ldr_gnt) begin
            mem_en   = 1'b1;
            mem_we   = ldr_we;
            mem_addr = ldr_addr;
            mem_din  = ldr_din;
        end
    end

    // Next state and read tracking.
    always_comb begin
        state_d    = state_q;
        rd_pend_d  = 1'b0;
        rd_owner_d = rd_owner_q;
        case (state_q)
            ARB_IDLE: if (ldr_gnt && ldr_lock) state_d = ARB_LOCK;
            ARB_LOCK: if (!ldr_lock || !ldr_req) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
        if (cpu_gnt && (cpu_we == '0)) begin
            rd_pend_d  = 1'b1;
            rd_owner_d = ARB_OWN_CPU;
        end else if (ldr_gnt && (ldr_we == '0)) begin
            rd_pend_d  = 1'b1;
            rd_owner_d = ARB_OWN_LDR;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= ARB_OWN_CPU;
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign cpu_rvalid = rd_pend_q && (rd_owner_q == ARB_OWN_CPU);
    assign ldr_rvalid = rd_pend_q && (rd_owner_q == ARB_OWN_LDR);
    assign cpu_dout   = cpu_rvalid ? mem_dout : '0;
    assign ldr_dout   = ldr_rvalid ? mem_dout : '0;

    // Starvation: count denied loader cycles, clear on any loader grant.
    mem_port_arbiter_sat_counter #(
        .W     (cnt_width(STARVE_LIM)),
        .LIMIT (STARVE_LIM)
    ) u_starve_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (ldr_gnt),
        .inc_i (ldr_req && !ldr_gnt),
        .cnt_o (dbg_starve_cnt),
        .sat_o (starve_sat)
    );

    // Burst: held at 0 in IDLE; the locking beat in IDLE loads 1. In LOCK it
    // counts loader beats and restarts from 0 at the forced CPU slot.
    assign burst_clr = (state_q == ARB_IDLE) || cpu_gnt;
    assign burst_inc = ldr_gnt && ((state_q == ARB_LOCK) || ldr_lock);

    mem_port_arbiter_sat_counter #(
        .W     (cnt_width(MAX_BURST)),
        .LIMIT (MAX_BURST)
    ) u_burst_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (burst_clr),
        .inc_i (burst_inc),
        .cnt_o (dbg_burst_cnt),
        .sat_o (burst_sat)
    );

    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Inputs change on the falling edge,
//   outputs are sampled 1 time unit later; the DUT clocks on the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [3:0]  cpu_we;
    logic [13:0] cpu_addr;
    logic [31:0] cpu_din;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_dout;
    logic        ldr_req;
    logic        ldr_lock;
    logic [3:0]  ldr_we;
    logic [13:0] ldr_addr;
    logic [31:0] ldr_din;
    logic        ldr_gnt;
    logic        ldr_rvalid;
    logic [31:0] ldr_dout;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    arb_state_e  dbg_state;
    logic [3:0]  dbg_starve_cnt;
    logic [4:0]  dbg_burst_cnt;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_din        (cpu_din),
        .cpu_gnt        (cpu_gnt),
        .cpu_rvalid     (cpu_rvalid),
        .cpu_dout       (cpu_dout),
        .ldr_req        (ldr_req),
        .ldr_lock       (ldr_lock),
        .ldr_we         (ldr_we),
        .ldr_addr       (ldr_addr),
        .ldr_din        (ldr_din),
        .ldr_gnt        (ldr_gnt),
        .ldr_rvalid     (ldr_rvalid),
        .ldr_dout       (ldr_dout),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .dbg_state      (dbg_state),
        .dbg_starve_cnt (dbg_starve_cnt),
        .dbg_burst_cnt  (dbg_burst_cnt)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [13:0] beat;
        logic        prev_cpu;
        logic [31:0] prev_data;

        // ---- 1. reset with every request high ----
        rst      = 1'b0;
        cpu_req  = 1'b1;
        ldr_req  = 1'b1;
        ldr_lock = 1'b1;
        cpu_we   = 4'h0;
        ldr_we   = 4'h0;
        cpu_addr = 14'h0010;
        ldr_addr = 14'h0020;
        cpu_din  = 32'h1111_1111;
        ldr_din  = 32'h2222_2222;
        mem_dout = 32'h5A5A_5A5A;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_ldr_gnt", ldr_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_ldr_rvalid", ldr_rvalid, 0);
        chk("rst_cpu_dout", cpu_dout, 0);
        chk("rst_ldr_dout", ldr_dout, 0);
        chk("rst_state", 32'(dbg_state), 32'(ARB_IDLE));

        @(negedge clk);
        rst      = 1'b1;
        cpu_req  = 1'b0;
        ldr_req  = 1'b0;
        ldr_lock = 1'b0;

        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 4'h0;
        cpu_addr = 14'h0010;
        #1;
        chk("rd1_cpu_gnt", cpu_gnt, 1);
        chk("rd1_ldr_gnt", ldr_gnt, 0);
        chk("rd1_mem_en", mem_en, 1);
        chk("rd1_mem_addr", mem_addr, 32'h0010);

        @(negedge clk);
        cpu_req  = 1'b0;
        mem_dout = 32'hCAFE_0010;
        #1;
        chk("rd1_cpu_rvalid", cpu_rvalid, 1);
        chk("rd1_cpu_dout", cpu_dout, 32'hCAFE_0010);
        chk("rd1_ldr_rvalid", ldr_rvalid, 0);
        chk("rd1_ldr_dout", ldr_dout, 0);

        // ---- 2. contention: CPU 8 cycles, then loader ----
        @(negedge clk);
        cpu_req  = 1'b1;
        ldr_req  = 1'b1;
        cpu_we   = 4'hF;
        ldr_we   = 4'hF;
        cpu_addr = 14'h0100;
        ldr_addr = 14'h0180;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("cont_cpu_gnt", cpu_gnt, 1);
            chk("cont_ldr_gnt", ldr_gnt, 0);
            chk("cont_starve", dbg_starve_cnt, i);
            @(negedge clk);
        end
        #1;
        chk("cont9_ldr_gnt", ldr_gnt, 1);
        chk("cont9_cpu_gnt", cpu_gnt, 0);
        chk("cont9_starve", dbg_starve_cnt, 8);
        chk("cont9_mem_addr", mem_addr, 32'h0180);
        @(negedge clk);
        #1;
        chk("cont10_starve", dbg_starve_cnt, 0);
        chk("cont10_cpu_gnt", cpu_gnt, 1);
        @(negedge clk);
        cpu_req = 1'b0;
        ldr_req = 1'b0;

        // ---- 3. locked burst: 16 loader, 1 CPU, 4 loader ----
        @(negedge clk);
        ldr_req  = 1'b1;
        ldr_lock = 1'b1;
        ldr_we   = 4'hF;
        ldr_din  = 32'hA5A5_0000;
        cpu_we   = 4'hF;
        cpu_addr = 14'h0200;
        beat     = 14'h0;
        for (int c = 0; c < 21; c++) begin
            if (c >= 1) cpu_req = 1'b1;
            if (c == 20) ldr_lock = 1'b0;
            ldr_addr = 14'h1000 + beat;
            #1;
            if (c == 17) chk("burst_restart", dbg_burst_cnt, 0);
            if (c == 16) begin
                chk("burst_cpu_slot_gnt", cpu_gnt, 1);
                chk("burst_cpu_slot_ldr", ldr_gnt, 0);
                chk("burst_cpu_slot_addr", mem_addr, 32'h0200);
            end else begin
                chk("burst_ldr_gnt", ldr_gnt, 1);
                chk("burst_cpu_denied", cpu_gnt, 0);
                chk("burst_ldr_addr", mem_addr, 32'(14'h1000 + beat));
                beat = beat + 14'h1;
            end
            chk("burst_state", 32'(dbg_state), (c == 0) ? 32'(ARB_IDLE) : 32'(ARB_LOCK));
            @(negedge clk);
        end
        ldr_req = 1'b0;
        #1;
        chk("unlock_state", 32'(dbg_state), 32'(ARB_IDLE));
        chk("unlock_cpu_gnt", cpu_gnt, 1);
        chk("unlock_mem_addr", mem_addr, 32'h0200);

        // ---- 4. read routing, alternating CPU / loader ----
        prev_cpu  = 1'b0;
        prev_data = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cpu_we   = 4'h0;
            ldr_we   = 4'h0;
            ldr_lock = 1'b0;
            cpu_addr = 14'h0004;
            ldr_addr = 14'h0008;
            cpu_req  = ((k % 2) == 0);
            ldr_req  = ((k % 2) == 1);
            mem_dout = 32'hD000_0000 + 32'(k);
            #1;
            if (k > 0) begin
                chk("route_cpu_rvalid", cpu_rvalid, prev_cpu);
                chk("route_ldr_rvalid", ldr_rvalid, !prev_cpu);
                chk("route_cpu_dout", cpu_dout, prev_cpu ? prev_data : 32'h0);
                chk("route_ldr_dout", ldr_dout, prev_cpu ? 32'h0 : prev_data);
            end
            chk("route_mem_addr", mem_addr, ((k % 2) == 0) ? 32'h4 : 32'h8);
            prev_cpu  = ((k % 2) == 0);
            prev_data = 32'hD000_0000 + 32'(k + 1);
        end
        @(negedge clk);
        cpu_req  = 1'b0;
        ldr_req  = 1'b0;
        mem_dout = 32'hD000_0004;
        #1;
        chk("route_last_ldr_rvalid", ldr_rvalid, 1);
        chk("route_last_ldr_dout", ldr_dout, 32'hD000_0004);
        chk("route_last_cpu_rvalid", cpu_rvalid, 0);
        chk("route_last_cpu_dout", cpu_dout, 0);

        // ---- 5. CPU byte write ----
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 4'b0100;
        cpu_din  = 32'h00AB_0000;
        cpu_addr = 14'h0020;
        #1;
        chk("bw_cpu_gnt", cpu_gnt, 1);
        chk("bw_mem_we", mem_we, 4'b0100);
        chk("bw_mem_din", mem_din, 32'h00AB_0000);
        chk("bw_mem_addr", mem_addr, 32'h0020);
        @(negedge clk);
        cpu_req = 1'b0;
        cpu_we  = 4'h0;
        #1;
        chk("bw_no_cpu_rvalid", cpu_rvalid, 0);
        chk("bw_no_ldr_rvalid", ldr_rvalid, 0);

        // ---- 6. reset in the middle of a locked burst ----
        @(negedge clk);
        ldr_req  = 1'b1;
        ldr_lock = 1'b1;
        ldr_we   = 4'hF;
        ldr_addr = 14'h1100;
        #1;
        chk("mid_lock_gnt", ldr_gnt, 1);
        @(negedge clk);
        ldr_we   = 4'h0;
        ldr_addr = 14'h1101;
        #1;
        chk("mid_rd_gnt", ldr_gnt, 1);
        chk("mid_rd_state", 32'(dbg_state), 32'(ARB_LOCK));
        chk("mid_rd_mem_we", mem_we, 0);
        #2;
        rst = 1'b0;
        @(negedge clk);
        mem_dout = 32'hBEEF_0001;
        #1;
        chk("mid_rst_ldr_rvalid", ldr_rvalid, 0);
        chk("mid_rst_ldr_dout", ldr_dout, 0);
        chk("mid_rst_ldr_gnt", ldr_gnt, 0);
        chk("mid_rst_state", 32'(dbg_state), 32'(ARB_IDLE));
        chk("mid_rst_burst", dbg_burst_cnt, 0);
        @(negedge clk);
        rst      = 1'b1;
        cpu_req  = 1'b1;
        cpu_we   = 4'h0;
        cpu_addr = 14'h0030;
        #1;
        chk("post_rst_cpu_gnt", cpu_gnt, 1);
        chk("post_rst_ldr_gnt", ldr_gnt, 0);
        chk("post_rst_state", 32'(dbg_state), 32'(ARB_IDLE));
        @(negedge clk);
        cpu_req  = 1'b0;
        ldr_req  = 1'b0;
        ldr_lock = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
